// File: rtl/branch_ex.sv
// branch_ex: branch execution unit. Resolves condition, target and link for
// issued branches and buffers the results in a small circular queue that
// drains to fetch/commit over a valid/ready redirect handshake.

package branch_ex_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned OP_W   = 4;

  // Branch opcodes; encodings outside this list behave like NOP.
  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2,
    OP_BLT  = 4'd3,
    OP_BGE  = 4'd4,
    OP_BLTU = 4'd5,
    OP_BGEU = 4'd6,
    OP_JAL  = 4'd7,
    OP_JALR = 4'd8
  } op_e;

  // One resolved branch as seen by fetch/commit.
  typedef struct packed {
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [DATA_W-1:0] link;
  } redir_t;

endpackage

module branch_ex
  import branch_ex_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              BranchWorkEn,
  input  logic [DATA_W-1:0] operandO,
  input  logic [DATA_W-1:0] operandT,
  input  logic [DATA_W-1:0] imm,
  input  logic [OP_W-1:0]   opCode,
  input  logic [ADDR_W-1:0] PC,
  output logic              BranchBusy,
  output logic              redirValid,
  input  logic              redirReady,
  output logic              redirTaken,
  output logic [ADDR_W-1:0] redirTarget,
  output logic [DATA_W-1:0] redirLink,
  output logic              overflowErr,
  output logic [CNT_W-1:0]  resolvedCnt,
  output logic [CNT_W-1:0]  takenCnt
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned QCNT_W = $clog2(DEPTH + 1);

  // Queue state
  redir_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_rd;
  logic [PTR_W-1:0]   r_wr;
  logic [QCNT_W-1:0]  r_cnt;

  // Registered outputs
  logic               r_valid;
  logic               r_busy;
  redir_t             r_head;
  logic               r_ovf;
  logic [CNT_W-1:0]   r_res_cnt;
  logic [CNT_W-1:0]   r_tkn_cnt;

  // Resolution datapath
  logic               w_op_ok;
  logic               w_taken;
  logic               w_eq;
  logic               w_lt_s;
  logic               w_lt_u;
  logic [ADDR_W-1:0]  w_pc4;
  logic [ADDR_W-1:0]  w_br_tgt;
  logic [ADDR_W-1:0]  w_jalr_sum;
  logic [ADDR_W-1:0]  w_jalr_tgt;
  redir_t             w_new;

  // Queue control
  logic               w_issue;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [QCNT_W-1:0]  w_cnt_nxt;
  logic [PTR_W-1:0]   w_rd_nxt;
  logic [PTR_W-1:0]   w_wr_nxt;
  redir_t             w_head_nxt;

  assign w_eq       = (operandO == operandT);
  assign w_lt_s     = ($signed(operandO) < $signed(operandT));
  assign w_lt_u     = (operandO < operandT);
  assign w_pc4      = PC + ADDR_W'(4);
  assign w_br_tgt   = PC + imm;
  assign w_jalr_sum = operandO + imm;
  assign w_jalr_tgt = w_jalr_sum & ~ADDR_W'(1);

  // Decode opcode into a taken decision; unknown encodings are not pushed.
  always_comb begin
    w_op_ok = 1'b1;
    w_taken = 1'b0;
    case (opCode)
      OP_BEQ:  w_taken = w_eq;
      OP_BNE:  w_taken = !w_eq;
      OP_BLT:  w_taken = w_lt_s;
      OP_BGE:  w_taken = !w_lt_s;
      OP_BLTU: w_taken = w_lt_u;
      OP_BGEU: w_taken = !w_lt_u;
      OP_JAL:  w_taken = 1'b1;
      OP_JALR: w_taken = 1'b1;
      default: w_op_ok = 1'b0;
    endcase
  end

  // Assemble the result entry for the instruction currently on the inputs.
  always_comb begin
    w_new        = '0;
    w_new.taken  = w_taken;
    w_new.link   = w_pc4;
    if (!w_taken) begin
      w_new.target = w_pc4;
    end else if (opCode == OP_JALR) begin
      w_new.target = w_jalr_tgt;
    end else begin
      w_new.target = w_br_tgt;
    end
  end

  // Push/pop decisions and next queue state; flush beats any same-edge push.
  always_comb begin
    w_issue   = BranchWorkEn && w_op_ok;
    w_full    = (r_cnt == QCNT_W'(DEPTH));
    w_pop     = r_valid && redirReady;
    w_push    = w_issue && !flush && (!w_full || w_pop);
    w_drop    = w_issue && !flush && w_full && !w_pop;
    w_cnt_nxt = r_cnt;
    w_rd_nxt  = r_rd;
    w_wr_nxt  = r_wr;
    if (flush) begin
      w_cnt_nxt = '0;
      w_rd_nxt  = '0;
      w_wr_nxt  = '0;
    end else begin
      if (w_pop) begin
        w_rd_nxt = r_rd + PTR_W'(1);
      end
      if (w_push) begin
        w_wr_nxt = r_wr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        w_cnt_nxt = r_cnt + QCNT_W'(1);
      end else if (!w_push && w_pop) begin
        w_cnt_nxt = r_cnt - QCNT_W'(1);
      end
    end
  end

  // Head entry after this edge; the entry being written may become the head.
  always_comb begin
    w_head_nxt = '0;
    if (w_cnt_nxt != '0) begin
      if (w_push && (r_wr == w_rd_nxt)) begin
        w_head_nxt = w_new;
      end else begin
        w_head_nxt = r_mem[w_rd_nxt];
      end
    end
  end

  // Queue storage; contents are qualified by the count, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= w_new;
    end
  end

  // Control state, registered head view, error flag and statistics.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd      <= '0;
      r_wr      <= '0;
      r_cnt     <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_head    <= '0;
      r_ovf     <= 1'b0;
      r_res_cnt <= '0;
      r_tkn_cnt <= '0;
    end else begin
      r_rd    <= w_rd_nxt;
      r_wr    <= w_wr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_cnt_nxt != '0);
      r_busy  <= (w_cnt_nxt == QCNT_W'(DEPTH));
      r_head  <= w_head_nxt;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
      if (w_push) begin
        r_res_cnt <= r_res_cnt + CNT_W'(1);
        if (w_new.taken) begin
          r_tkn_cnt <= r_tkn_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign BranchBusy  = r_busy;
  assign redirValid  = r_valid;
  assign redirTaken  = r_head.taken;
  assign redirTarget = r_head.target;
  assign redirLink   = r_head.link;
  assign overflowErr = r_ovf;
  assign resolvedCnt = r_res_cnt;
  assign takenCnt    = r_tkn_cnt;

endmodule

// File: tb/tb_branch_ex.sv
// Directed testbench for branch_ex: resolution, queueing, back-pressure,
// overflow, flush and reset behaviour.

module tb_branch_ex;
  import branch_ex_pkg::*;

  localparam int unsigned CNT_W = 16;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              BranchWorkEn;
  logic [DATA_W-1:0] operandO;
  logic [DATA_W-1:0] operandT;
  logic [DATA_W-1:0] imm;
  logic [OP_W-1:0]   opCode;
  logic [ADDR_W-1:0] PC;
  logic              BranchBusy;
  logic              redirValid;
  logic              redirReady;
  logic              redirTaken;
  logic [ADDR_W-1:0] redirTarget;
  logic [DATA_W-1:0] redirLink;
  logic              overflowErr;
  logic [CNT_W-1:0]  resolvedCnt;
  logic [CNT_W-1:0]  takenCnt;

  int n_chk  = 0;
  int n_pass = 0;

  branch_ex #(.DEPTH(2), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .BranchWorkEn(BranchWorkEn),
    .operandO    (operandO),
    .operandT    (operandT),
    .imm         (imm),
    .opCode      (opCode),
    .PC          (PC),
    .BranchBusy  (BranchBusy),
    .redirValid  (redirValid),
    .redirReady  (redirReady),
    .redirTaken  (redirTaken),
    .redirTarget (redirTarget),
    .redirLink   (redirLink),
    .overflowErr (overflowErr),
    .resolvedCnt (resolvedCnt),
    .takenCnt    (takenCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [OP_W-1:0] op, input logic [31:0] o,
                       input logic [31:0] t, input logic [31:0] im,
                       input logic [31:0] pc);
    BranchWorkEn = 1'b1;
    opCode       = op;
    operandO     = o;
    operandT     = t;
    imm          = im;
    PC           = pc;
  endtask

  task automatic idle();
    BranchWorkEn = 1'b0;
    opCode       = OP_NOP;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic chk_head(input string tag, input logic v, input logic tk,
                          input logic [31:0] tgt, input logic [31:0] lnk);
    chk({tag, "_valid"},  32'(redirValid),  32'(v));
    chk({tag, "_taken"},  32'(redirTaken),  32'(tk));
    chk({tag, "_target"}, redirTarget, tgt);
    chk({tag, "_link"},   redirLink,   lnk);
  endtask

  initial begin
    rst        = 1'b0;
    flush      = 1'b0;
    redirReady = 1'b0;
    issue(OP_BEQ, 32'd5, 32'd5, 32'h20, 32'h100);

    // Reset held two cycles with an issue pending
    tick();
    tick();
    chk_head("rst", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("rst_busy", 32'(BranchBusy), 32'd0);
    chk("rst_ovf", 32'(overflowErr), 32'd0);
    chk("rst_res", 32'(resolvedCnt), 32'd0);
    chk("rst_tkn", 32'(takenCnt), 32'd0);

    // First issue after reset: BEQ equal
    rst = 1'b1;
    tick();
    idle();
    chk_head("beq", 1'b1, 1'b1, 32'h120, 32'h104);
    chk("beq_res", 32'(resolvedCnt), 32'd1);
    chk("beq_tkn", 32'(takenCnt), 32'd1);

    // Pop it
    redirReady = 1'b1;
    tick();
    chk("beq_pop_valid", 32'(redirValid), 32'd0);

    // Streaming condition coverage with ready held high
    issue(OP_BLT, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300);
    tick();
    chk_head("blt", 1'b1, 1'b1, 32'h340, 32'h304);
    issue(OP_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h300);
    tick();
    chk_head("bltu", 1'b1, 1'b0, 32'h304, 32'h304);
    issue(OP_BNE, 32'd7, 32'd7, 32'h10, 32'h400);
    tick();
    chk_head("bne", 1'b1, 1'b0, 32'h404, 32'h404);
    issue(OP_BGE, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h500);
    tick();
    chk_head("bge", 1'b1, 1'b0, 32'h504, 32'h504);
    issue(OP_BGEU, 32'hFFFF_FFFF, 32'd1, 32'h8, 32'h600);
    tick();
    chk_head("bgeu", 1'b1, 1'b1, 32'h608, 32'h604);
    chk("cond_tkn", 32'(takenCnt), 32'd3);
    issue(OP_JALR, 32'h1001, 32'd0, 32'h4, 32'h200);
    tick();
    chk_head("jalr", 1'b1, 1'b1, 32'h1004, 32'h204);
    issue(OP_JAL, 32'd0, 32'd0, 32'h8, 32'hFFFF_FFFC);
    tick();
    chk_head("jal_wrap", 1'b1, 1'b1, 32'h4, 32'h0);
    chk("jal_res", 32'(resolvedCnt), 32'd8);
    chk("jal_tkn", 32'(takenCnt), 32'd5);

    // NOP issue: ignored, head popped
    issue(OP_NOP, 32'd1, 32'd1, 32'h4, 32'h700);
    tick();
    idle();
    chk("nop_valid", 32'(redirValid), 32'd0);
    chk("nop_res", 32'(resolvedCnt), 32'd8);
    chk("nop_ovf", 32'(overflowErr), 32'd0);

    // Back-pressure: fill, overflow, then drain in order
    redirReady = 1'b0;
    issue(OP_BEQ, 32'd1, 32'd2, 32'h10, 32'h10);
    tick();
    chk("bp1_busy", 32'(BranchBusy), 32'd0);
    chk_head("bp1", 1'b1, 1'b0, 32'h14, 32'h14);
    issue(OP_JAL, 32'd0, 32'd0, 32'h100, 32'h20);
    tick();
    chk("bp2_busy", 32'(BranchBusy), 32'd1);
    chk_head("bp2_hold", 1'b1, 1'b0, 32'h14, 32'h14);
    issue(OP_BEQ, 32'd0, 32'd0, 32'h4, 32'h30);
    tick();
    idle();
    chk("bp3_ovf", 32'(overflowErr), 32'd1);
    chk("bp3_res", 32'(resolvedCnt), 32'd10);
    chk("bp3_busy", 32'(BranchBusy), 32'd1);
    chk_head("bp3_hold", 1'b1, 1'b0, 32'h14, 32'h14);
    redirReady = 1'b1;
    tick();
    chk("drain1_busy", 32'(BranchBusy), 32'd0);
    chk_head("drain1", 1'b1, 1'b1, 32'h120, 32'h24);
    tick();
    chk("drain2_valid", 32'(redirValid), 32'd0);
    chk("drain2_ovf", 32'(overflowErr), 32'd1);
    chk("drain2_tkn", 32'(takenCnt), 32'd6);

    // Reset mid-operation with two queued entries
    redirReady = 1'b0;
    issue(OP_BNE, 32'd1, 32'd2, 32'h20, 32'h40);
    tick();
    issue(OP_BLTU, 32'd1, 32'd2, 32'h30, 32'h50);
    tick();
    idle();
    chk("pre_rst_busy", 32'(BranchBusy), 32'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_valid", 32'(redirValid), 32'd0);
    chk("mid_rst_busy", 32'(BranchBusy), 32'd0);
    chk("mid_rst_ovf", 32'(overflowErr), 32'd0);
    chk("mid_rst_res", 32'(resolvedCnt), 32'd0);

    // Full queue with simultaneous push and pop
    issue(OP_BEQ, 32'd3, 32'd3, 32'h10, 32'h1000);
    tick();
    issue(OP_BLT, 32'd1, 32'd2, 32'h20, 32'h2000);
    tick();
    chk("full_busy", 32'(BranchBusy), 32'd1);
    chk_head("full_head", 1'b1, 1'b1, 32'h1010, 32'h1004);
    issue(OP_BGEU, 32'd1, 32'd2, 32'h40, 32'h3000);
    redirReady = 1'b1;
    tick();
    idle();
    chk("pp_busy", 32'(BranchBusy), 32'd1);
    chk("pp_ovf", 32'(overflowErr), 32'd0);
    chk("pp_res", 32'(resolvedCnt), 32'd3);
    chk_head("pp_head", 1'b1, 1'b1, 32'h2020, 32'h2004);
    tick();
    chk("pp2_busy", 32'(BranchBusy), 32'd0);
    chk_head("pp2_head", 1'b1, 1'b0, 32'h3004, 32'h3004);
    tick();
    chk("pp3_valid", 32'(redirValid), 32'd0);
    chk("pp3_tkn", 32'(takenCnt), 32'd2);

    // Flush with a same-edge issue
    redirReady = 1'b0;
    issue(OP_JAL, 32'd0, 32'd0, 32'h8, 32'h40);
    tick();
    chk_head("pre_flush", 1'b1, 1'b1, 32'h48, 32'h44);
    chk("pre_flush_res", 32'(resolvedCnt), 32'd4);
    issue(OP_BEQ, 32'd9, 32'd9, 32'h8, 32'h80);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    chk_head("flush", 1'b0, 1'b0, 32'h0, 32'h0);
    chk("flush_busy", 32'(BranchBusy), 32'd0);
    chk("flush_res", 32'(resolvedCnt), 32'd4);
    chk("flush_tkn", 32'(takenCnt), 32'd3);
    chk("flush_ovf", 32'(overflowErr), 32'd0);

    // Queue usable after flush
    issue(OP_JALR, 32'h2000, 32'd0, 32'h11, 32'h500);
    tick();
    idle();
    chk_head("post_flush", 1'b1, 1'b1, 32'h2010, 32'h504);
    chk("post_flush_res", 32'(resolvedCnt), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
